mem_serial_issue: RTL and testbench

Parametrised memory-stage request sequencer for the multi-issue pipeline. Latches up to LANES memory micro-ops from the execute/memory boundary and issues them in program order over a single dbus port with a valid/addr_ok/data_ok handshake. It generates store write data and byte strobes, aligns and extends load data, and squashes younger lanes behind an exception. It holds the pipeline with `stall` until every issued access has completed.

---
 rtl/mem_serial_issue.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mem_serial_issue.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_serial_issue.sv
// mem_serial_issue: memory-stage request sequencer for the multi-issue pipeline.
// Latches up to LANES memory micro-ops when start is seen in IDLE, then issues
// them oldest-first (lane LANES-1 down to lane 0) over one dbus port with a
// valid/addr_ok/data_ok handshake. It builds store data and strobes, aligns and
// extends load data, and squashes every lane at and below the oldest killing lane.
//
// Ports
//   clk, resetn         clock, synchronous active-low reset
//   start               new lane bundle (sampled only in IDLE)
//   lane_load/store     per-lane access type
//   lane_kill           lane carries an exception/ERET; it and younger lanes not issued
//   lane_msize          per-lane size (2 bits): 0 byte, 1 half, 2 word
//   lane_sext           per-lane load sign-extend
//   lane_addr/wdata     per-lane address and raw store operand (32 bits each)
//   flush               abort the current bundle
//   dreq_*              bus request (valid, addr, size, strobe, data, uncached)
//   dresp_*             bus response (addr_ok, data_ok, data)
//   lane_rdata          aligned load results (32 bits per lane, 0 if not issued)
//   lane_excp/_store    misaligned-access exception per lane (1 = AdES, 0 = AdEL)
//   stall               pipeline hold
//   done                one-cycle pulse, results valid
//
// Build option: define MEM_MISALIGN_EXC_EN to enable alignment exceptions.
// Without it, lane_excp/lane_excp_store are 0 and addresses issue as given.

module mem_serial_issue #(
    parameter int unsigned LANES        = 2,
    parameter int unsigned UNCACHED_BIT = 29
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [LANES-1:0]      lane_load,
    input  logic [LANES-1:0]      lane_store,
    input  logic [LANES-1:0]      lane_kill,
    input  logic [2*LANES-1:0]    lane_msize,
    input  logic [LANES-1:0]      lane_sext,
    input  logic [32*LANES-1:0]   lane_addr,
    input  logic [32*LANES-1:0]   lane_wdata,
    input  logic                  flush,
    output logic                  dreq_valid,
    output logic [31:0]           dreq_addr,
    output logic [1:0]            dreq_size,
    output logic [3:0]            dreq_strobe,
    output logic [31:0]           dreq_data,
    output logic                  dreq_uncached,
    input  logic                  dresp_addr_ok,
    input  logic                  dresp_data_ok,
    input  logic [31:0]           dresp_data,
    output logic [32*LANES-1:0]   lane_rdata,
    output logic [LANES-1:0]      lane_excp,
    output logic [LANES-1:0]      lane_excp_store,
    output logic                  stall,
    output logic                  done
);

    localparam int unsigned PW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 latch_c, capture_c;

    logic [LANES-1:0]     mask_q, load_q, store_q, sext_q, excp_q, excp_st_q;
    logic [2*LANES-1:0]   msize_q;
    logic [32*LANES-1:0]  addr_q, wdata_q, rdata_q;

    logic [LANES-1:0]     mis_c, mis_st_c, start_mask_c;
    logic [PW-1:0]        first_ptr_c, next_ptr_c;
    logic                 next_found_c;

    logic [31:0]          sel_addr, sel_wdata, sel_shift, sel_ext;
    logic [1:0]           sel_size;
    logic                 sel_load, sel_store, sel_sext;

    // Start-time decode: misalignment, kill chain from the oldest lane, first lane.
    always_comb begin
        logic killed;
        mis_c        = '0;
        mis_st_c     = '0;
        start_mask_c = '0;
        first_ptr_c  = '0;
        killed       = 1'b0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
`ifdef MEM_MISALIGN_EXC_EN
            if (lane_load[i] || lane_store[i]) begin
                case (lane_msize[2*i +: 2])
                    2'd0:    mis_c[i] = 1'b0;
                    2'd1:    mis_c[i] = lane_addr[32*i];
                    default: mis_c[i] = |lane_addr[32*i +: 2];
                endcase
            end
            mis_st_c[i] = mis_c[i] & lane_store[i];
`endif
            // A killing lane is itself excluded along with all younger lanes.
            if (lane_kill[i] || mis_c[i]) killed = 1'b1;
            start_mask_c[i] = !killed && (lane_load[i] || lane_store[i]);
        end
        for (int i = 0; i < int'(LANES); i++) begin
            if (start_mask_c[i]) first_ptr_c = PW'(i);
        end
    end

    // Next active lane below the current pointer (ascending scan keeps the highest).
    always_comb begin
        next_ptr_c   = '0;
        next_found_c = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (mask_q[i] && (PW'(i) < ptr_q)) begin
                next_ptr_c   = PW'(i);
                next_found_c = 1'b1;
            end
        end
    end

    // Fields of the lane currently under the pointer.
    always_comb begin
        sel_addr  = addr_q[{ptr_q, 5'd0} +: 32];
        sel_wdata = wdata_q[{ptr_q, 5'd0} +: 32];
        sel_size  = msize_q[{ptr_q, 1'b0} +: 2];
        sel_load  = load_q[ptr_q];
        sel_store = store_q[ptr_q];
        sel_sext  = sext_q[ptr_q];
    end

    // Store data replication and byte strobes.
    always_comb begin
        dreq_data   = sel_wdata;
        dreq_strobe = 4'b1111;
        case (sel_size)
            2'd0: begin
                dreq_data   = {4{sel_wdata[7:0]}};
                dreq_strobe = 4'b0001 << sel_addr[1:0];
            end
            2'd1: begin
                dreq_data   = {2{sel_wdata[15:0]}};
                dreq_strobe = sel_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (!sel_store) dreq_strobe = 4'b0000;
    end

    // Load alignment and extension.
    always_comb begin
        sel_shift = dresp_data >> {sel_addr[1:0], 3'b000};
        case (sel_size)
            2'd0:    sel_ext = {{24{sel_sext & sel_shift[7]}}, sel_shift[7:0]};
            2'd1:    sel_ext = {{16{sel_sext & sel_shift[15]}}, sel_shift[15:0]};
            default: sel_ext = sel_shift;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Next-state logic; a flush after addr_ok still drains the outstanding data beat.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        flush_pend_d = flush_pend_q;
        latch_c      = 1'b0;
        capture_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    latch_c      = 1'b1;
                    flush_pend_d = 1'b0;
                    if (start_mask_c == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                        ptr_d   = first_ptr_c;
                    end
                end
            end
            S_REQ: begin
                if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        if (flush) begin
                            state_d = S_IDLE;
                        end else begin
                            capture_c = 1'b1;
                            state_d   = next_found_c ? S_REQ : S_DONE;
                            if (next_found_c) ptr_d = next_ptr_c;
                        end
                    end else begin
                        state_d      = S_WAIT;
                        flush_pend_d = flush;
                    end
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    if (flush || flush_pend_q) begin
                        state_d      = S_IDLE;
                        flush_pend_d = 1'b0;
                    end else begin
                        capture_c = 1'b1;
                        state_d   = next_found_c ? S_REQ : S_DONE;
                        if (next_found_c) ptr_d = next_ptr_c;
                    end
                end else if (flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane bundle latch, exception latch and load result capture.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mask_q    <= '0;
            load_q    <= '0;
            store_q   <= '0;
            sext_q    <= '0;
            msize_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            excp_q    <= '0;
            excp_st_q <= '0;
            rdata_q   <= '0;
        end else if (latch_c) begin
            mask_q    <= start_mask_c;
            load_q    <= lane_load;
            store_q   <= lane_store;
            sext_q    <= lane_sext;
            msize_q   <= lane_msize;
            addr_q    <= lane_addr;
            wdata_q   <= lane_wdata;
            excp_q    <= mis_c;
            excp_st_q <= mis_st_c;
            rdata_q   <= '0;
        end else if (capture_c && sel_load) begin
            rdata_q[{ptr_q, 5'd0} +: 32] <= sel_ext;
        end
    end

    assign dreq_valid      = (state_q == S_REQ);
    assign dreq_addr       = sel_addr;
    assign dreq_size       = sel_size;
    assign dreq_uncached   = sel_addr[UNCACHED_BIT];
    assign lane_rdata      = rdata_q;
    assign lane_excp       = excp_q;
    assign lane_excp_store = excp_st_q;
    assign done            = (state_q == S_DONE);
    assign stall           = (state_q == S_REQ) || (state_q == S_WAIT) ||
                             ((state_q == S_IDLE) && start);

endmodule

// File: tb/tb_mem_serial_issue.sv
module tb_mem_serial_issue;

    localparam int unsigned LANES = 2;

    logic                clk = 1'b0;
    logic                resetn, start, flush;
    logic [LANES-1:0]    lane_load, lane_store, lane_kill, lane_sext;
    logic [2*LANES-1:0]  lane_msize;
    logic [32*LANES-1:0] lane_addr, lane_wdata;
    logic                dreq_valid, dreq_uncached;
    logic [31:0]         dreq_addr, dreq_data;
    logic [1:0]          dreq_size;
    logic [3:0]          dreq_strobe;
    logic                dresp_addr_ok, dresp_data_ok;
    logic [31:0]         dresp_data;
    logic [32*LANES-1:0] lane_rdata;
    logic [LANES-1:0]    lane_excp, lane_excp_store;
    logic                stall, done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_serial_issue #(.LANES(LANES), .UNCACHED_BIT(29)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .lane_load(lane_load), .lane_store(lane_store), .lane_kill(lane_kill),
        .lane_msize(lane_msize), .lane_sext(lane_sext),
        .lane_addr(lane_addr), .lane_wdata(lane_wdata), .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dreq_uncached(dreq_uncached),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .lane_rdata(lane_rdata), .lane_excp(lane_excp), .lane_excp_store(lane_excp_store),
        .stall(stall), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference rules written as plain arithmetic.
    function automatic logic [31:0] ref_sdata(input logic [31:0] w, input logic [1:0] sz);
        if (sz == 2'd0) return {24'd0, w[7:0]} * 32'h0101_0101;
        if (sz == 2'd1) return {16'd0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [3:0] ref_strobe(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return 4'(1 << a[1:0]);
        if (sz == 2'd1) return a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] r, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sx);
        int nb;
        logic [31:0] v, m;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v  = r >> (8 * int'(a[1:0]));
        if (nb == 4) return v;
        m = (32'd1 << (8 * nb)) - 32'd1;
        v = v & m;
        if (sx && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_MISALIGN_EXC_EN
        return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
`else
        return (a[0] & 1'b0) != 1'b0;
`endif
    endfunction

    task automatic set_lane(input int i, input bit ld, input bit st, input bit kl,
                            input logic [1:0] sz, input bit sx,
                            input logic [31:0] a, input logic [31:0] w);
        lane_load[i]          = ld;
        lane_store[i]         = st;
        lane_kill[i]          = kl;
        lane_msize[2*i +: 2]  = sz;
        lane_sext[i]          = sx;
        lane_addr[32*i +: 32] = a;
        lane_wdata[32*i +: 32] = w;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < int'(LANES); i++) begin
            int kind;
            kind = int'($urandom_range(2));
            set_lane(i, kind == 1, kind == 2, $urandom_range(7) == 0,
                     2'($urandom_range(2)), 1'($urandom_range(1)), $urandom, $urandom);
        end
    endtask

    // Presents the current lane inputs with start, plays bus slave and checks
    // every request and the final results against the reference rules.
    task automatic run_bundle(input int aok_pct, input int lat_fix, input bit fix_data,
                              input logic [31:0] fdata, output int lat_done);
        int          q[$];
        logic [31:0] ea[LANES], ew[LANES], er[LANES];
        logic [1:0]  esz[LANES];
        logic        eld[LANES], est[LANES], esx[LANES], eex[LANES], ees[LANES];
        bit          stop, pend, got_done;
        int          cnt, lat, l;
        stop = 0; pend = 0; got_done = 0; cnt = 0; lat_done = -1;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            bit mem, mis;
            ea[i] = lane_addr[32*i +: 32];   ew[i] = lane_wdata[32*i +: 32];
            esz[i] = lane_msize[2*i +: 2];   eld[i] = lane_load[i];
            est[i] = lane_store[i];          esx[i] = lane_sext[i];
            er[i] = 32'd0;
            mem = eld[i] | est[i];
            mis = mem && ref_misaligned(ea[i], esz[i]);
            eex[i] = mis;
            ees[i] = mis & est[i];
            if (lane_kill[i] || mis) stop = 1;
            if (!stop && mem) q.push_back(i);
        end
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                rand_lanes();
            end
            dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b0;
            dresp_data    = $urandom;
            if (done) begin
                got_done = 1;
                lat_done = c;
                check("stall_in_done", stall, 0);
                break;
            end
            check("stall_busy", stall, 1);
            l = -1;
            if (pend) begin
                check("valid_in_wait", dreq_valid, 0);
                if (cnt == 0) begin
                    pend = 0;
                    l = q[0];
                end else begin
                    cnt--;
                end
            end else if (dreq_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_req", dreq_valid, 0);
                end else begin
                    check("req_addr", dreq_addr, ea[q[0]]);
                    check("req_size", dreq_size, esz[q[0]]);
                    check("req_strobe", dreq_strobe, est[q[0]] ? ref_strobe(ea[q[0]], esz[q[0]]) : 4'h0);
                    check("req_uncached", dreq_uncached, ea[q[0]][29]);
                    if (est[q[0]]) check("req_data", dreq_data, ref_sdata(ew[q[0]], esz[q[0]]));
                    if (int'($urandom_range(99)) < aok_pct) begin
                        dresp_addr_ok = 1'b1;
                        lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(2));
                        if (lat == 0) l = q[0];
                        else begin
                            pend = 1;
                            cnt  = lat - 1;
                        end
                    end
                end
            end
            if (l >= 0) begin
                dresp_data_ok = 1'b1;
                if (fix_data) dresp_data = fdata;
                er[l] = eld[l] ? ref_load(dresp_data, ea[l], esz[l], esx[l]) : 32'd0;
                void'(q.pop_front());
            end
        end
        check("done_seen", got_done, 1);
        check("all_issued", q.size(), 0);
        for (int i = 0; i < int'(LANES); i++) begin
            check($sformatf("rdata%0d", i), lane_rdata[32*i +: 32], er[i]);
            check($sformatf("excp%0d", i), lane_excp[i], eex[i]);
            check($sformatf("excp_store%0d", i), lane_excp_store[i], ees[i]);
        end
        @(negedge clk);
        check("done_pulse", done, 0);
        check("stall_idle", stall, 0);
    endtask

    task automatic clear_lanes();
        lane_load = '0; lane_store = '0; lane_kill = '0; lane_sext = '0;
        lane_msize = '0; lane_addr = '0; lane_wdata = '0;
    endtask

    initial begin
        int lat;
        resetn = 1'b0; start = 1'b0; flush = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
        clear_lanes();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", dreq_valid, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        check("rst_rdata", lane_rdata, 0);
        check("rst_excp", lane_excp, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Word load then byte store, zero-wait bus.
        clear_lanes();
        set_lane(1, 1, 0, 0, 2'd2, 0, 32'h0000_1000, 32'h0);
        set_lane(0, 0, 1, 0, 2'd0, 0, 32'h0000_2003, 32'h0000_00AB);
        run_bundle(100, 0, 1, 32'hDEAD_BEEF, lat);
        check("t1_latency", lat, 3);
        check("t1_rdata1", lane_rdata[63:32], 32'hDEAD_BEEF);

        // Signed half load with a two-cycle data_ok delay.
        clear_lanes();
        set_lane(1, 1, 0, 0, 2'd1, 1, 32'h0000_1002, 32'h0);
        run_bundle(100, 2, 1, 32'h8001_FFFF, lat);
        check("t2_rdata1", lane_rdata[63:32], 32'hFFFF_8001);

        // Killed oldest lane squashes the younger store.
        clear_lanes();
        set_lane(1, 1, 0, 1, 2'd2, 0, 32'h0000_1000, 32'h0);
        set_lane(0, 0, 1, 0, 2'd2, 0, 32'h0000_2000, 32'h1234_5678);
        run_bundle(100, 0, 0, 32'h0, lat);
        check("t3_latency", lat, 1);

        // Misaligned word store in the oldest lane.
        clear_lanes();
        set_lane(1, 0, 1, 0, 2'd2, 0, 32'h0000_1001, 32'hCAFE_F00D);
        set_lane(0, 1, 0, 0, 2'd2, 0, 32'h0000_3000, 32'h0);
        run_bundle(100, 0, 0, 32'h0, lat);
`ifdef MEM_MISALIGN_EXC_EN
        check("t4_excp1", lane_excp[1], 1);
        check("t4_excp_store1", lane_excp_store[1], 1);
        check("t4_latency", lat, 1);
`else
        check("t4_excp1", lane_excp[1], 0);
        check("t4_latency", lat, 3);
`endif

        // addr_ok withheld; flush before it is accepted.
        clear_lanes();
        set_lane(1, 0, 1, 0, 2'd1, 0, 32'h2000_3002, 32'h0000_5A5A);
        set_lane(0, 1, 0, 0, 2'd2, 0, 32'h0000_3004, 32'h0);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (c == 2);
            if (c <= 2) begin
                check("t5_valid", dreq_valid, 1);
                check("t5_addr", dreq_addr, 32'h2000_3002);
                check("t5_strobe", dreq_strobe, 4'hC);
                check("t5_data", dreq_data, 32'h5A5A_5A5A);
                check("t5_uncached", dreq_uncached, 1);
            end else begin
                check("t5_no_req", dreq_valid, 0);
                check("t5_no_done", done, 0);
                check("t5_stall", stall, 0);
            end
        end
        flush = 1'b0;

        // Flush while waiting for data: the beat is drained and discarded.
        clear_lanes();
        set_lane(1, 1, 0, 0, 2'd2, 0, 32'h0000_4000, 32'h0);
        set_lane(0, 0, 1, 0, 2'd2, 0, 32'h0000_4004, 32'h1111_2222);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            dresp_addr_ok = (c == 1);
            dresp_data_ok = (c == 4);
            dresp_data    = 32'h7777_8888;
            flush         = (c == 2);
            if (c == 1) check("t6_valid", dreq_valid, 1);
            if (c >= 2) check("t6_no_req", dreq_valid, 0);
            check("t6_no_done", done, 0);
            if (c <= 4) check("t6_stall_wait", stall, 1);
            else        check("t6_stall_idle", stall, 0);
        end
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; flush = 1'b0;
        check("t6_rdata1", lane_rdata[63:32], 32'h0);

        // Reset while a transaction is in flight.
        clear_lanes();
        set_lane(1, 1, 0, 0, 2'd2, 0, 32'h0000_5000, 32'h0);
        set_lane(0, 1, 0, 0, 2'd2, 0, 32'h0000_5004, 32'h0);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dresp_addr_ok = 1'b1;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        check("t7_wait_stall", stall, 1);
        resetn = 1'b0;
        @(negedge clk);
        check("t7_valid", dreq_valid, 0);
        check("t7_stall", stall, 0);
        check("t7_done", done, 0);
        check("t7_rdata", lane_rdata, 0);
        resetn = 1'b1;
        clear_lanes();
        set_lane(1, 1, 0, 0, 2'd0, 1, 32'h0000_6001, 32'h0);
        set_lane(0, 0, 1, 0, 2'd1, 0, 32'h0000_6002, 32'h0000_BEEF);
        run_bundle(100, 0, 1, 32'h0000_8000, lat);
        check("t7_after_latency", lat, 3);
        check("t7_after_rdata1", lane_rdata[63:32], 32'hFFFF_FF80);

        // Randomised bundles with random bus back-pressure.
        for (int n = 0; n < 60; n++) begin
            rand_lanes();
            run_bundle(60, -1, 0, 32'h0, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
